// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one outstanding op, IDLE -> ISSUE -> RESP.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority (port 0).
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
`ifdef MEM_ARB_RR_EN
  logic                  ptr_q, ptr_d;
`endif

  logic                  gnt;
  logic                  hs;
  logic                  gnt_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Pick the winner and raise its ready only while idle and out of reset.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    gnt = (&req_valid) ? ~ptr_q : req_valid[1];
`else
    gnt = (&req_valid) ? 1'b0 : req_valid[1];
`endif
    hs        = rst_n && (state_q == IDLE) && (|req_valid);
    req_ready = hs ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    gnt_we    = req_we[gnt];
    sel_addr  = gnt ? req_addr1 : req_addr0;
    sel_wdata = gnt ? req_wdata1 : req_wdata0;
  end

  // Next state and next registered outputs; strobes default low.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    rsp_valid_d = 2'b00;
`ifdef MEM_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          port_d  = gnt;
          we_d    = gnt_we;
          wr_en_d = gnt_we;
          rd_en_d = ~gnt_we;
          addr_d  = sel_addr;
          wdata_d = gnt_we ? sel_wdata : '0;
`ifdef MEM_ARB_RR_EN
          ptr_d   = gnt;
`endif
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d     = RESP;
          rsp_valid_d = port_q ? 2'b10 : 2'b01;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
`ifdef MEM_ARB_RR_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef MEM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign mem_wr_en = wr_en_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (state_q == RESP) ? mem_rdata : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model with a reference memory.
module tb_mem_arbiter;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = '0;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [DW-1:0] req_wdata0 = '0;
  logic [DW-1:0] req_wdata1 = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // External memory: data valid the cycle after a read strobe, noise otherwise.
  logic [DW-1:0] tmem [8];
  always @(posedge clk) begin
    if (mem_wr_en) tmem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? tmem[mem_addr] : DW'($urandom);
  end

  // Reference model: expected events per cycle number.
  bit [DW-1:0] ref_mem [8];
  bit          e_wr  [MAXC];
  bit          e_rd  [MAXC];
  bit [AW-1:0] e_adr [MAXC];
  bit [DW-1:0] e_wd  [MAXC];
  bit [1:0]    e_rsp [MAXC];
  bit [DW-1:0] e_rdd [MAXC];
  int          cyc;
  int          free_c;
  int          last_hs;
  int          hs_cyc;
  int          g_port;
`ifdef MEM_ARB_RR_EN
  bit          ptr;
`endif

  // Requester-side stimulus state.
  logic [1:0]    rv;
  logic [1:0]    rwe;
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];

  logic [1:0]    o_rsp;
  logic [DW-1:0] o_data;
  logic [1:0]    cur_rsp;
  logic [1:0]    cur_rdy;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    int g;
    logic [1:0] rdy_exp;
    bit busy_exp;
    req_valid  = rv;
    req_we     = rwe;
    req_addr0  = ra[0];
    req_addr1  = ra[1];
    req_wdata0 = rd[0];
    req_wdata1 = rd[1];
    g = -1;
    if (!rst_n) begin
      for (int k = cyc; k < cyc + 3; k++) begin
        e_wr[k]  = 1'b0;
        e_rd[k]  = 1'b0;
        e_rsp[k] = 2'b00;
      end
      free_c  = cyc + 1;
      last_hs = cyc;
`ifdef MEM_ARB_RR_EN
      ptr     = 1'b1;
`endif
    end else if (cyc >= free_c && rv != 2'b00) begin
      if (rv == 2'b11) begin
`ifdef MEM_ARB_RR_EN
        g = ptr ? 0 : 1;
`else
        g = 0;
`endif
      end else begin
        g = rv[1] ? 1 : 0;
      end
    end
    rdy_exp  = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    busy_exp = (cyc > last_hs) && (cyc < free_c);
    @(negedge clk);
    chk("ready", req_ready, rdy_exp);
    chk("wr_en", mem_wr_en, e_wr[cyc]);
    chk("rd_en", mem_rd_en, e_rd[cyc]);
    if (e_wr[cyc] || e_rd[cyc]) begin
      chk("mem_addr", mem_addr, e_adr[cyc]);
      chk("mem_wdata", mem_wdata, e_wd[cyc]);
    end
    chk("rsp_valid", rsp_valid, e_rsp[cyc]);
    chk("rsp_rdata", rsp_rdata, (e_rsp[cyc] != 0) ? e_rdd[cyc] : 8'h00);
    chk("busy", busy, busy_exp);
    cur_rsp = rsp_valid;
    cur_rdy = req_ready;
    if (rsp_valid != 2'b00) begin
      o_rsp  = rsp_valid;
      o_data = rsp_rdata;
    end
    if (e_wr[cyc]) ref_mem[e_adr[cyc]] = e_wd[cyc];
    if (g >= 0) begin
      e_wr[cyc+1]  = rwe[g];
      e_rd[cyc+1]  = !rwe[g];
      e_adr[cyc+1] = ra[g];
      e_wd[cyc+1]  = rwe[g] ? rd[g] : 8'h00;
      if (!rwe[g]) begin
        e_rsp[cyc+2] = (g == 1) ? 2'b10 : 2'b01;
        e_rdd[cyc+2] = ref_mem[ra[g]];
      end
      last_hs = cyc;
      hs_cyc  = cyc;
      free_c  = cyc + (rwe[g] ? 2 : 3);
`ifdef MEM_ARB_RR_EN
      ptr     = (g == 1);
`endif
    end
    g_port = g;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req_one(input int p, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done   = 1'b0;
    rv[p]  = 1'b1;
    rwe[p] = we;
    ra[p]  = a;
    rd[p]  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (g_port == p) done = 1'b1;
    end
    rv[p] = 1'b0;
    if (!done) chk("req_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int h1;
  int n0;
  int n1;

  initial begin
    for (int i = 0; i < 8; i++) begin
      tmem[i]    = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    rv = '0; rwe = '0;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    cyc = 0; free_c = 0; last_hs = -1; hs_cyc = 0; g_port = -1;
`ifdef MEM_ARB_RR_EN
    ptr = 1'b1;
`endif
    o_rsp = '0; o_data = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rv = 2'b11;
    idle(3);
    rv = 2'b00;
    rst_n = 1'b1;

    // Write then read back from port 0.
    req_one(0, 1'b1, 3'd3, 8'hA5);
    o_rsp = '0;
    req_one(0, 1'b0, 3'd3, 8'h00);
    idle(4);
    chk("t35_port", o_rsp, 2'b01);
    chk("t35_data", o_data, 8'hA5);

    // Port 1 write followed straight away by port 0 read.
    req_one(1, 1'b1, 3'd0, 8'h3C);
    h1 = hs_cyc;
    o_rsp = '0;
    req_one(0, 1'b0, 3'd0, 8'h00);
    chk("t39_gap", hs_cyc - h1, 2);
    idle(4);
    chk("t39_data", o_data, 8'h3C);
    chk("t39_port", o_rsp, 2'b01);

    // Both ports reading continuously, starting from reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rv = 2'b11; rwe = 2'b00; ra[0] = 3'd5; ra[1] = 3'd6;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (cur_rsp[0]) n0++;
      if (cur_rsp[1]) n1++;
    end
    rv = 2'b00;
    idle(4);
`ifdef MEM_ARB_RR_EN
    chk("t36_rsp0", n0, 4);
    chk("t36_rsp1", n1, 4);
`else
    chk("t37_rsp0", n0, 8);
    chk("t37_rsp1", n1, 0);
`endif

    // Reset while a port 1 read sits in ISSUE.
    req_one(1, 1'b0, 3'd7, 8'h00);
    rst_n = 1'b0;
    step();
    chk("t38_busy", busy, 0);
    rst_n = 1'b1;
    n1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cur_rsp != 2'b00) n1++;
    end
    chk("t38_norsp", n1, 0);
    rv = 2'b11; rwe = 2'b00;
    step();
    chk("t38_first", cur_rdy, 2'b01);
    rv = 2'b00;
    idle(4);

    // Random traffic with occasional resets and abandoned requests.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      step();
      for (int p = 0; p < 2; p++) begin
        if (g_port == p) rv[p] = 1'b0;
        if (!rv[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            rv[p]  = 1'b1;
            rwe[p] = 1'($urandom);
            ra[p]  = AW'($urandom);
            rd[p]  = DW'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          rv[p] = 1'b0;
        end
      end
    end
    rst_n = 1'b1;
    rv = 2'b00;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of write data, read data and memory data buses.
REQ-002 Parameter ADDR_WIDTH, default 3, width of request and memory address buses.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-006 req_ready  output  2  per-requester accept, at most one bit high.
REQ-007 req_we  input  2  per-requester op: 1 write, 0 read.
REQ-008 req_addr0, req_addr1  input  ADDR_WIDTH each  request address.
REQ-009 req_wdata0, req_wdata1  input  DATA_WIDTH each  write data.
REQ-010 rsp_valid  output  2  one-cycle read-response strobe per requester.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data, meaningful only while a rsp_valid bit is high.
REQ-012 mem_wr_en, mem_rd_en  output  1 each  memory command strobes.
REQ-013 mem_addr  output  ADDR_WIDTH;  mem_wdata  output  DATA_WIDTH  memory command fields.
REQ-014 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after the cycle mem_rd_en is high.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-017 req_ready SHALL be nonzero only in IDLE, combinationally from req_valid and the priority pointer.
REQ-018 A handshake SHALL be req_valid[i] && req_ready[i]; the requester holds valid, we, addr and wdata stable until then.
REQ-019 On handshake: register port index, op, addr and wdata; go to ISSUE.
REQ-020 In ISSUE, mem_wr_en (write) or mem_rd_en (read) SHALL be high for exactly one cycle, with mem_addr/mem_wdata from the registered request; mem_wdata SHALL be 0 for reads.
REQ-021 From ISSUE, a write SHALL return to IDLE with no response; a read SHALL go to RESP.
REQ-022 In RESP, rsp_valid[port] SHALL be high for one cycle with rsp_rdata = mem_rdata; FSM then returns to IDLE.
REQ-023 Latency: read handshake at cycle N -> rsp_valid at N+2; write handshake at N -> mem_wr_en at N+1; next grant earliest N+3 (read) or N+2 (write).
REQ-024 Only one requester valid: it SHALL be granted regardless of pointer.
REQ-025 Both valid: grant per REQ-033/REQ-034.
REQ-026 Outside ISSUE, mem_wr_en and mem_rd_en SHALL be 0; outside RESP, rsp_valid SHALL be 0 and rsp_rdata 0.
REQ-027 Dropping req_valid without a handshake SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force IDLE with all outputs 0 and the priority pointer = 1, so requester 0 wins the first contention.
REQ-029 Reset during ISSUE or RESP SHALL abort the operation with no memory strobe or response afterwards; the requester must re-request.
REQ-030 After rst_n deasserts, the first grant SHALL be possible in the first IDLE cycle.

Configuration
REQ-031 Macro MEM_ARB_RR_EN SHALL select the contention policy.
REQ-032 The pointer SHALL update to the granted index on every handshake when MEM_ARB_RR_EN is defined.
REQ-033 With MEM_ARB_RR_EN defined, contention SHALL grant the requester not equal to the pointer (round-robin).
REQ-034 Without MEM_ARB_RR_EN, contention SHALL always grant requester 0 (fixed priority); the pointer logic SHALL be absent.

Verification
REQ-035 Reset, requester 0 writes addr 3 data 0xA5, then reads addr 3 -> mem_wr_en one cycle with addr 3/0xA5; rsp_valid=2'b01, rsp_rdata=0xA5 two cycles after the read handshake.
REQ-036 Both requesters continuously reading, RR enabled -> grants alternate 0,1,0,1; each rsp_valid bit strobes every 6 cycles.
REQ-037 Same stimulus, MEM_ARB_RR_EN undefined -> requester 0 always granted; rsp_valid[1] never high.
REQ-038 Requester 1 read of addr 7 with rst_n pulsed low during ISSUE -> no rsp_valid, busy=0, next contention grants requester 0.
REQ-039 Requester 1 write addr 0 data 0x3C, then immediately requester 0 read addr 0 -> read returns 0x3C; handshakes two cycles apart.
REQ-040 Random requests with a reference memory model -> every rsp_rdata matches; req_ready never 2'b11 and never high outside IDLE.
